// File: rtl/rat_path_tracker_if.sv
// ============================================================================
//  Module   : rat_path_tracker_if
//  Purpose  : Solver/replay handshake bundle between the maze solver side and
//             the rat path tracker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rat_path_tracker_if #(
    parameter int CW = 4,
    parameter int AW = 8
);
    logic          done;
    logic          fail;
    logic [1:0]    move;
    logic          move_valid;
    logic          move_last;
    logic          run;
    logic          replay;
    logic [1:0]    out_move;
    logic          out_valid;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [AW:0]   path_len;
    logic          ready;
    logic          no_path;
    logic          err;

    modport master (
        output done, fail, move, move_valid, move_last, replay,
        input  run, out_move, out_valid, row, col, path_len, ready, no_path, err
    );

    modport slave (
        input  done, fail, move, move_valid, move_last, replay,
        output run, out_move, out_valid, row, col, path_len, ready, no_path, err
    );
endinterface

`default_nettype wire

// File: rtl/rat_path_tracker.sv
// ============================================================================
//  Module   : rat_path_tracker
//  Purpose  : Captures the solved move sequence, tracks and bounds-checks the
//             rat position, and replays the stored path one move per cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rat_path_tracker #(
    parameter int N     = 16,
    parameter int CW    = 4,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rat_path_tracker_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_READY   = 3'd2,
        S_REPLAY  = 3'd3,
        S_NOFAIL  = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [1:0]    r_mem [DEPTH];
    logic [1:0]    r_rd_data;
    logic          r_rd_valid;
    logic [AW:0]   r_path_len;
    logic [AW:0]   r_rp;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [1:0]    r_out_move;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_oob;
    logic          w_ovf;
    logic          w_store;
    logic [2*CW-1:0] w_cap_pos;
    logic [2*CW-1:0] w_rep_pos;

    // True when the move would leave the N x N grid from (row, col).
    function automatic logic f_oob(input logic [1:0] mv,
                                   input logic [CW-1:0] row,
                                   input logic [CW-1:0] col);
        logic v;
        case (mv)
            2'b00:   v = (col == CW'(N - 1));
            2'b01:   v = (row == CW'(N - 1));
            2'b10:   v = (col == '0);
            default: v = (row == '0);
        endcase
        return v;
    endfunction

    function automatic logic [2*CW-1:0] f_step(input logic [1:0] mv,
                                               input logic [CW-1:0] row,
                                               input logic [CW-1:0] col);
        logic [CW-1:0] r;
        logic [CW-1:0] c;
        r = row;
        c = col;
        case (mv)
            2'b00:   c = col + CW'(1);
            2'b01:   r = row + CW'(1);
            2'b10:   c = col - CW'(1);
            default: r = row - CW'(1);
        endcase
        return {r, c};
    endfunction

    assign w_accept  = (r_state == S_CAPTURE) && bus.move_valid;
    assign w_oob     = f_oob(bus.move, r_row, r_col);
    assign w_ovf     = (r_path_len == (AW+1)'(DEPTH));
    assign w_store   = w_accept && !w_oob && !w_ovf;
    assign w_cap_pos = f_step(bus.move, r_row, r_col);
    assign w_rep_pos = f_step(r_rd_data, r_row, r_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.fail) begin
                    w_state_next = S_NOFAIL;
                end else if (bus.done) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_accept && (w_oob || w_ovf)) begin
                    w_state_next = S_ERR;
                end else if (w_store && bus.move_last) begin
                    w_state_next = S_READY;
                end
            end
            S_READY: begin
                if (bus.replay) begin
                    w_state_next = S_REPLAY;
                end
            end
            S_REPLAY: begin
                // Leave only once the final read has drained to the output stage.
                if ((r_rp == r_path_len) && !r_rd_valid) begin
                    w_state_next = S_READY;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    // The stored length doubles as the write pointer.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_path_len[AW-1:0]] <= bus.move;
        end
        r_rd_data <= r_mem[r_rp[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_path_len  <= '0;
            r_rp        <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_rd_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_move  <= 2'b00;
        end else begin
            r_rd_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.done && !bus.fail) begin
                        r_path_len <= '0;
                        r_row      <= '0;
                        r_col      <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_store) begin
                        r_path_len     <= r_path_len + (AW+1)'(1);
                        {r_row, r_col} <= w_cap_pos;
                    end
                end
                S_READY: begin
                    if (bus.replay) begin
                        r_rp  <= '0;
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                S_REPLAY: begin
                    if (r_rp != r_path_len) begin
                        r_rp       <= r_rp + (AW+1)'(1);
                        r_rd_valid <= 1'b1;
                    end
                    if (r_rd_valid) begin
                        r_out_valid    <= 1'b1;
                        r_out_move     <= r_rd_data;
                        {r_row, r_col} <= w_rep_pos;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.run       = (r_state == S_CAPTURE);
    assign bus.ready     = (r_state == S_READY);
    assign bus.no_path   = (r_state == S_NOFAIL);
    assign bus.err       = (r_state == S_ERR);
    assign bus.out_valid = r_out_valid;
    assign bus.out_move  = r_out_move;
    assign bus.row       = r_row;
    assign bus.col       = r_col;
    assign bus.path_len  = r_path_len;

endmodule

`default_nettype wire

// File: tb/tb_rat_path_tracker.sv
// ============================================================================
//  Module   : tb_rat_path_tracker
//  Purpose  : Self-checking bench for rat_path_tracker with a reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rat_path_tracker;

    localparam int N       = 16;
    localparam int DEPTH_A = 256;

    localparam int M_IDLE   = 0;
    localparam int M_CAP    = 1;
    localparam int M_READY  = 2;
    localparam int M_REPLAY = 3;
    localparam int M_NOFAIL = 4;
    localparam int M_ERR    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    rat_path_tracker_if #(.CW(4), .AW(8)) bus_a ();
    rat_path_tracker_if #(.CW(4), .AW(2)) bus_b ();

    rat_path_tracker #(.N(16), .CW(4), .DEPTH(256), .AW(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    rat_path_tracker #(.N(16), .CW(4), .DEPTH(4), .AW(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int drow(input logic [1:0] m);
        return (m == 2'b01) ? 1 : (m == 2'b11) ? -1 : 0;
    endfunction

    function automatic int dcol(input logic [1:0] m);
        return (m == 2'b00) ? 1 : (m == 2'b10) ? -1 : 0;
    endfunction

    // Reference model for instance A: mode, stored path queue, position, replay clock.
    int         m_mode = M_IDLE;
    int         m_row  = 0;
    int         m_col  = 0;
    int         m_len  = 0;
    int         m_k    = 0;
    logic [1:0] m_buf [$];
    logic       m_ov   = 1'b0;
    logic [1:0] m_om   = 2'b00;

    always @(posedge clk or posedge rst) begin : model_p
        int nr;
        int nc;
        if (rst) begin
            m_mode = M_IDLE;
            m_row  = 0;
            m_col  = 0;
            m_len  = 0;
            m_ov   = 1'b0;
            m_om   = 2'b00;
            m_buf.delete();
        end else begin
            m_ov = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (bus_a.fail) begin
                        m_mode = M_NOFAIL;
                    end else if (bus_a.done) begin
                        m_mode = M_CAP;
                        m_row  = 0;
                        m_col  = 0;
                        m_len  = 0;
                        m_buf.delete();
                    end
                end
                M_CAP: begin
                    if (bus_a.move_valid) begin
                        nr = m_row + drow(bus_a.move);
                        nc = m_col + dcol(bus_a.move);
                        if (nr < 0 || nr > N-1 || nc < 0 || nc > N-1 || m_len == DEPTH_A) begin
                            m_mode = M_ERR;
                        end else begin
                            m_buf.push_back(bus_a.move);
                            m_len++;
                            m_row = nr;
                            m_col = nc;
                            if (bus_a.move_last) m_mode = M_READY;
                        end
                    end
                end
                M_READY: begin
                    if (bus_a.replay) begin
                        m_mode = M_REPLAY;
                        m_k    = 0;
                        m_row  = 0;
                        m_col  = 0;
                    end
                end
                M_REPLAY: begin
                    m_k++;
                    if (m_k >= 2 && m_k - 2 < m_len) begin
                        m_ov  = 1'b1;
                        m_om  = m_buf[m_k-2];
                        m_row = m_row + drow(m_om);
                        m_col = m_col + dcol(m_om);
                    end
                    if (m_k == m_len + 2) m_mode = M_READY;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        check("m_run",      bus_a.run,       m_mode == M_CAP);
        check("m_ready",    bus_a.ready,     m_mode == M_READY);
        check("m_no_path",  bus_a.no_path,   m_mode == M_NOFAIL);
        check("m_err",      bus_a.err,       m_mode == M_ERR);
        check("m_path_len", bus_a.path_len,  m_len);
        check("m_row",      bus_a.row,       m_row);
        check("m_col",      bus_a.col,       m_col);
        check("m_out_valid", bus_a.out_valid, m_ov);
        check("m_out_move", bus_a.out_move,  m_om);
    end

    task automatic step_a(input logic d, input logic f, input logic mv, input logic ml,
                          input logic [1:0] m, input logic rp);
        bus_a.done       = d;
        bus_a.fail       = f;
        bus_a.move_valid = mv;
        bus_a.move_last  = ml;
        bus_a.move       = m;
        bus_a.replay     = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic d, input logic mv, input logic [1:0] m);
        bus_b.done       = d;
        bus_b.move_valid = mv;
        bus_b.move       = m;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [1:0] e_om  [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        int         e_row [5] = '{0, 0, 1, 2, 3};
        int         e_col [5] = '{1, 2, 2, 2, 2};

        bus_a.done = 0; bus_a.fail = 0; bus_a.move = 0;
        bus_a.move_valid = 0; bus_a.move_last = 0; bus_a.replay = 0;
        bus_b.done = 0; bus_b.fail = 0; bus_b.move = 0;
        bus_b.move_valid = 0; bus_b.move_last = 0; bus_b.replay = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_run",      bus_a.run,      0);
        check("rst_ready",    bus_a.ready,    0);
        check("rst_len",      bus_a.path_len, 0);
        check("rst_err",      bus_a.err,      0);
        check("rst_out_valid", bus_a.out_valid, 0);
        rst = 1'b0;

        // Asynchronous reset in the middle of capture.
        step_a(1, 0, 0, 0, 2'b00, 0);
        check("cap_run", bus_a.run, 1);
        step_a(0, 0, 1, 0, 2'b00, 0);
        step_a(0, 0, 1, 0, 2'b01, 0);
        step_a(0, 0, 1, 0, 2'b00, 0);
        check("cap3_len", bus_a.path_len, 3);
        check("cap3_col", bus_a.col, 2);
        step_a(0, 0, 0, 0, 2'b00, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_run", bus_a.run, 0);
        check("midrst_len", bus_a.path_len, 0);
        check("midrst_row", bus_a.row, 0);
        check("midrst_col", bus_a.col, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Clean capture with a stall.
        step_a(1, 0, 0, 0, 2'b00, 0);
        check("restart_run", bus_a.run, 1);
        check("restart_len", bus_a.path_len, 0);
        step_a(0, 0, 1, 0, 2'b00, 0);
        step_a(0, 0, 1, 0, 2'b00, 0);
        step_a(0, 0, 0, 0, 2'b11, 0);
        step_a(0, 0, 1, 0, 2'b01, 0);
        step_a(0, 0, 1, 0, 2'b01, 0);
        step_a(0, 0, 1, 1, 2'b01, 0);
        check("done_run",   bus_a.run, 0);
        check("done_ready", bus_a.ready, 1);
        check("done_len",   bus_a.path_len, 5);
        check("done_row",   bus_a.row, 3);
        check("done_col",   bus_a.col, 2);
        step_a(0, 0, 0, 0, 2'b00, 0);

        // Replay, with a stray pulse mid-playback.
        bus_a.replay = 1'b1;
        @(posedge clk);
        #1 bus_a.replay = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rep_valid", bus_a.out_valid, (i >= 2 && i <= 6));
            if (i >= 2 && i <= 6) begin
                check("rep_move", bus_a.out_move, e_om[i-2]);
                check("rep_row",  bus_a.row,      e_row[i-2]);
                check("rep_col",  bus_a.col,      e_col[i-2]);
            end
            if (i == 3) bus_a.replay = 1'b1;
            if (i == 4) bus_a.replay = 1'b0;
        end
        check("rep_ready_after", bus_a.ready, 1);
        check("rep_valid_after", bus_a.out_valid, 0);

        // Out-of-bounds first move.
        #1 pulse_rst();
        step_a(1, 0, 0, 0, 2'b00, 0);
        step_a(0, 0, 1, 0, 2'b11, 0);
        check("oob_err", bus_a.err, 1);
        check("oob_len", bus_a.path_len, 0);
        check("oob_row", bus_a.row, 0);
        check("oob_run", bus_a.run, 0);
        step_a(1, 0, 0, 0, 2'b00, 1);
        step_a(0, 0, 1, 1, 2'b00, 0);
        step_a(0, 0, 0, 0, 2'b00, 0);
        check("oob_sticky", bus_a.err, 1);
        check("oob_len_hold", bus_a.path_len, 0);

        // Fail and Done together.
        pulse_rst();
        step_a(1, 1, 0, 0, 2'b00, 0);
        check("fail_nopath", bus_a.no_path, 1);
        check("fail_run", bus_a.run, 0);
        step_a(0, 0, 0, 0, 2'b00, 1);
        step_a(0, 0, 0, 0, 2'b00, 0);
        step_a(0, 0, 0, 0, 2'b00, 0);
        check("fail_ready", bus_a.ready, 0);
        check("fail_valid", bus_a.out_valid, 0);
        check("fail_sticky", bus_a.no_path, 1);

        // Overflow on the small-buffer instance.
        pulse_rst();
        step_b(1, 0, 2'b00);
        for (int i = 0; i < 4; i++) step_b(0, 1, 2'b00);
        check("ovf4_err", bus_b.err, 0);
        check("ovf4_len", bus_b.path_len, 4);
        check("ovf4_run", bus_b.run, 1);
        step_b(0, 1, 2'b00);
        check("ovf5_err", bus_b.err, 1);
        check("ovf5_len", bus_b.path_len, 4);
        check("ovf5_col", bus_b.col, 4);
        check("ovf5_run", bus_b.run, 0);
        step_b(0, 0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rat_path_tracker.md
Name: rat_path_tracker

Overview:
- Downstream consumer of the maze-solver top: once the solver reports Done, this block drives Run to pull the solved move sequence and stores it in a path buffer.
- While capturing, it tracks the rat's (row, col) position and checks every move against the maze bounds.
- On request it replays the stored path one move per cycle with the running coordinates, for display or board output.
- If the solver reports Fail, the block records the failure and no path is captured.

Parameters:
- N, 16, maze dimension (N x N); coordinates are 0..N-1.
- CW, 4, coordinate width, clog2(N).
- DEPTH, 256, path buffer depth, in moves.
- AW, 8, buffer address/count width, clog2(DEPTH).

Ports:
- CLK input 1 clock; all state changes on the rising edge.
- RST input 1 asynchronous active-high reset.
- Done input 1 solver finished with a path.
- Fail input 1 solver finished with no path.
- Move input 2 move code: 00=right (col+1), 01=down (row+1), 10=left (col-1), 11=up (row-1).
- MoveValid input 1 Move is valid this cycle while Run is high.
- MoveLast input 1 qualifies the final valid move.
- Run output 1 request to the solver to stream moves.
- Replay input 1 single-cycle pulse that starts playback.
- OutMove output 2 replayed move.
- OutValid output 1 OutMove, Row and Col are valid.
- Row output CW current row.
- Col output CW current column.
- PathLen output AW+1 number of stored moves.
- Ready output 1 path captured and idle; Replay is accepted.
- NoPath output 1 solver reported Fail.
- Err output 1 out-of-bounds move or buffer overflow.

Behaviour:
- Reset (async, any state): state=IDLE; Run=0, OutValid=0, OutMove=00, Row=0, Col=0, PathLen=0, Ready=0, NoPath=0, Err=0; write and read pointers=0. Buffer contents are don't-care.
- IDLE:
  - Fail=1 -> NOFAIL, NoPath=1. Fail has priority if Done and Fail are asserted together.
  - Done=1 -> CAPTURE, Run=1 from the next cycle. Row/Col are cleared to (0,0).
- CAPTURE:
  - Run held at 1.
  - Each cycle with MoveValid=1: write Move at the write pointer, PathLen+1, update Row/Col per the encoding.
  - MoveValid=1 with MoveLast=1: the move is stored, then go to READY with Run=0 on the next cycle.
  - Bounds: any move that would make Row or Col <0 or >N-1 -> ERR. That move is not stored and Row/Col do not change.
  - Overflow: MoveValid when PathLen==DEPTH -> ERR.
  - MoveValid=0 cycles are ignored, so stalls of any length are allowed.
- READY:
  - Ready=1.
  - Row/Col hold the final position.
  - Replay=1 -> REPLAY. Row/Col reset to (0,0) and the read pointer to 0 on that edge. Ready=0.
- REPLAY:
  - One move per cycle. OutValid=1 with OutMove = buffer[rp]. Row/Col show the position after that move, registered in the same cycle as OutValid.
  - Latency from Replay pulse to the first OutValid is 2 cycles (one synchronous buffer read).
  - After PathLen moves: OutValid=0, return to READY.
  - Replay pulses during REPLAY are ignored.
- PathLen==0 (MoveLast qualified a zero-length path is impossible; a Replay with PathLen 0 cannot occur): not applicable by construction. A Replay in IDLE, CAPTURE, NOFAIL or ERR is ignored.
- NOFAIL, ERR: sticky until RST. Run=0, OutValid=0.
- Done/Fail seen outside IDLE: ignored.
- Row/Col arithmetic is CW-bit unsigned. The bounds check is done before the update, so values never wrap.

Test Plan:
- Reset mid-CAPTURE after 3 moves -> next cycle Run=0, PathLen=0, Row=Col=0, state IDLE; a new Done restarts capture cleanly.
- Done, then moves 00,00,01,01,01(Last) with one MoveValid=0 stall inserted -> Run deasserts after the last move; PathLen=5, (Row,Col)=(3,2), Ready=1.
- Replay pulse after the previous scenario -> OutValid high for exactly 5 consecutive cycles starting 2 cycles after the pulse; OutMove 00,00,01,01,01; (Row,Col) (0,1),(0,2),(1,2),(2,2),(3,2); then Ready=1.
- Fail and Done asserted in the same cycle in IDLE -> NoPath=1, Run stays 0, Replay is ignored.
- First captured move 11 (up from row 0) -> Err=1, PathLen=0, Row=0, Run=0; Err holds until RST.
- N=16, DEPTH=4: stream 5 valid moves without MoveLast -> Err=1 on the 5th move, PathLen=4.
